// File: rtl/pio_poll_pkg.sv
// Shared types and defaults for the PIO polling master.
package pio_poll_pkg;
  typedef enum logic [2:0] {IDLE, RD, RLAT, CMP, WR} state_t;

  localparam logic [15:0] DEF_SRC_ADDR     = 16'h0000;
  localparam logic [15:0] DEF_DST_ADDR     = 16'h0010;
  localparam int          MAX_READ_LATENCY = 3;
endpackage

// File: rtl/poll_timer.sv
// Poll interval down-counter: reload has priority, otherwise counts while enabled.
module poll_timer #(
  parameter int POLL_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  input  logic reload,
  output logic expired
);
  localparam int TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD_VAL = TW'(POLL_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt <= RELOAD_VAL;
    else if (reload)   cnt <= RELOAD_VAL;
    else if (count_en) cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM initiator: polls a switch PIO and mirrors changed values to an LED PIO.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int                DATA_W       = 18,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] SRC_ADDR     = ADDR_W'(DEF_SRC_ADDR),
  parameter logic [ADDR_W-1:0] DST_ADDR     = ADDR_W'(DEF_DST_ADDR),
  parameter int                POLL_CYCLES  = 50000,
  parameter int                READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] last_value,
  output logic              change_pulse,
  output logic [15:0]       change_count
);
  localparam int LW = $clog2(MAX_READ_LATENCY + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  logic [LW-1:0]     lat_cnt;
  logic              valid, upd;
  logic [DATA_W-1:0] sample, rd_val;
  logic              tmr_zero, tmr_run, tmr_reload;
  logic              unused_hi;

  assign rd_val     = avm_readdata[DATA_W-1:0];
  assign unused_hi  = ^avm_readdata[31:DATA_W];
  assign tmr_run    = (state == IDLE) && enable;
  assign tmr_reload = (state == IDLE) && (!enable || tmr_zero);

  poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .count_en (tmr_run),
    .reload   (tmr_reload),
    .expired  (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && tmr_zero) state_nxt = RD;
      RD:      if (!avm_waitrequest)   state_nxt = RLAT;
      RLAT:    if (lat_cnt == '0)      state_nxt = CMP;
      CMP:     state_nxt = upd ? WR : IDLE;
      WR:      if (!avm_waitrequest)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they never depend
  // combinationally on waitrequest/readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      last_value    <= '0;
      change_pulse  <= 1'b0;
      change_count  <= '0;
      lat_cnt       <= '0;
      valid         <= 1'b0;
      upd           <= 1'b0;
      sample        <= '0;
    end else begin
      avm_read     <= (state_nxt == RD);
      avm_write    <= (state_nxt == WR);
      avm_address  <= (state_nxt == RD) ? SRC_ADDR :
                      (state_nxt == WR) ? DST_ADDR : '0;
      change_pulse <= 1'b0;

      if (state == RD && !avm_waitrequest)   lat_cnt <= LAT_INIT;
      else if (state == RLAT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;

      // Compare at capture so the pulse lands exactly in the CMP cycle.
      if (state == RLAT && lat_cnt == '0) begin
        sample       <= rd_val;
        upd          <= !valid || (rd_val != last_value);
        change_pulse <= valid && (rd_val != last_value);
      end

      if (state == CMP && upd) begin
        last_value    <= sample;
        valid         <= 1'b1;
        avm_writedata <= 32'(sample);
        if (change_pulse && change_count != 16'hFFFF)
          change_count <= change_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_pio_poll_master.sv
// Scoreboard bench: stimulus pushes expected writes/changes, a monitor pops on bus events.
module tb_pio_poll_master;
  logic        clk = 1'b0;
  logic        reset_n, enable, enable3;
  logic [15:0] address, address3;
  logic        rd, wr, rd3, wr3;
  logic [31:0] wdata, wdata3, rdata, rdata3;
  logic        wait_r, wait3;
  logic [17:0] lv, lv3, sw, sw3;
  logic        cp, cp3;
  logic [15:0] cc, cc3;

  int total = 0, bad = 0;
  int rd_stall = 0, wr_stall = 0, rd_acc = 0, wr_acc = 0;
  int lat = 0, lat3 = 0;

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [17:0] v; logic [15:0] c; } ch_t;
  wr_t wq[$], wq3[$];
  ch_t cq[$];
  ch_t pend;
  logic chk_pend = 1'b0;

  always #5 clk = ~clk;

  pio_poll_master #(.POLL_CYCLES(8), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(address), .avm_read(rd), .avm_write(wr), .avm_writedata(wdata),
    .avm_readdata(rdata), .avm_waitrequest(wait_r),
    .last_value(lv), .change_pulse(cp), .change_count(cc)
  );

  pio_poll_master #(.POLL_CYCLES(6), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(enable3),
    .avm_address(address3), .avm_read(rd3), .avm_write(wr3), .avm_writedata(wdata3),
    .avm_readdata(rdata3), .avm_waitrequest(wait3),
    .last_value(lv3), .change_pulse(cp3), .change_count(cc3)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(logic [17:0] v);
    wq.push_back('{a: 16'h0010, d: {14'b0, v}});
  endtask

  task automatic push_ch(logic [17:0] v, logic [15:0] c);
    cq.push_back('{v: v, c: c});
  endtask

  task automatic wait_empty(string name, int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (wq.size() == 0 && cq.size() == 0 && wq3.size() == 0 && !chk_pend) break;
      @(negedge clk);
    end
    chk(name, i < budget, 1);
  endtask

  task automatic wait_reads(int n, int budget);
    int i;
    int r0;
    r0 = rd_acc;
    for (i = 0; i < budget; i++) begin
      if (rd_acc - r0 >= n) break;
      @(negedge clk);
    end
    chk("read_progress", i < budget, 1);
  endtask

  // Slave for dut: programmable stalls, readdata valid only in accept+1.
  initial begin
    wait_r = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        wait_r = 1'b0;
        lat    = 0;
        rdata  = 32'hDEAD_BEEF;
      end else begin
        rdata = 32'hDEAD_BEEF;
        if (lat > 0) begin
          lat--;
          if (lat == 0) rdata = {14'h3A5A, sw};
        end
        wait_r = 1'b0;
        if (rd && rd_stall > 0) begin wait_r = 1'b1; rd_stall--; end
        else if (wr && wr_stall > 0) begin wait_r = 1'b1; wr_stall--; end
        if (rd && !wait_r) begin rd_acc++; lat = 1; end
        if (wr && !wait_r) wr_acc++;
      end
    end
  end

  // Slave for dut3: never stalls, garbage except in accept+3.
  initial begin
    rdata3 = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        lat3   = 0;
        rdata3 = '0;
      end else begin
        rdata3 = {14'h0, ~sw3};
        if (lat3 > 0) begin
          lat3--;
          if (lat3 == 0) rdata3 = {14'h1555, sw3};
        end
        if (rd3) lat3 = 3;
      end
    end
  end

  // Monitor: pops expectations on write accepts and change pulses.
  initial begin
    logic        prev_rs, prev_ws, prev_cp;
    logic [15:0] prev_addr;
    logic [31:0] prev_wd;
    wr_t         w;
    prev_rs = 0; prev_ws = 0; prev_cp = 0; prev_addr = '0; prev_wd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_rs = 0; prev_ws = 0; prev_cp = 0; chk_pend = 0;
      end else begin
        if (chk_pend) begin
          chk("last_value", 32'(lv), 32'(pend.v));
          chk("change_count", 32'(cc), 32'(pend.c));
          chk_pend = 0;
        end
        if (prev_rs) chk("rd_hold", {15'b0, rd, address}, {15'b0, 1'b1, prev_addr});
        if (prev_ws) begin
          chk("wr_hold", {15'b0, wr, address}, {15'b0, 1'b1, prev_addr});
          chk("wr_data_hold", wdata, prev_wd);
        end
        if (rd || wr) chk("rd_wr_excl", 32'(rd & wr), 0);
        if (prev_cp) chk("pulse_width", 32'(cp), 0);
        if (rd && !wait_r) chk("rd_addr", 32'(address), 32'h0000);
        if (wr && !wait_r) begin
          if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got data %h none expected", wdata);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", 32'(address), 32'(w.a));
            chk("wr_data", wdata, w.d);
          end
        end
        if (cp) begin
          if (cq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: got pulse none expected");
          end else begin
            pend = cq.pop_front();
            chk_pend = 1;
          end
        end
        if (wr3) begin
          if (wq3.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write3: got data %h none expected", wdata3);
          end else begin
            w = wq3.pop_front();
            chk("wr3_addr", 32'(address3), 32'(w.a));
            chk("wr3_data", wdata3, w.d);
          end
        end
        prev_rs   = rd && wait_r;
        prev_ws   = wr && wait_r;
        prev_cp   = cp;
        prev_addr = address;
        prev_wd   = wdata;
      end
    end
  end

  initial begin
    int r0, w0, i;
    reset_n = 1'b0; enable = 1'b0; enable3 = 1'b0; wait3 = 1'b0;
    sw = 18'h00005; sw3 = 18'h2C0DE;
    #17;
    chk("rst_read", 32'(rd), 0);
    chk("rst_write", 32'(wr), 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_last", 32'(lv), 0);
    chk("rst_pulse", 32'(cp), 0);
    chk("rst_count", 32'(cc), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // First sample is written, never counted.
    push_wr(18'h00005);
    enable = 1'b1;
    wait_empty("first_write", 60);
    w0 = wr_acc;
    wait_reads(2, 60);
    repeat (6) @(negedge clk);
    chk("no_write_unchanged", wr_acc - w0, 0);
    chk("count_after_first", 32'(cc), 0);

    // 5 -> 3FFFF between polls.
    sw = 18'h3FFFF;
    push_wr(18'h3FFFF);
    push_ch(18'h3FFFF, 16'd1);
    wait_empty("change_write", 60);
    w0 = wr_acc;
    wait_reads(1, 60);
    repeat (6) @(negedge clk);
    chk("no_write_unchanged2", wr_acc - w0, 0);

    // Stalls: 3 cycles on read, 2 on write.
    r0 = rd_acc; w0 = wr_acc;
    rd_stall = 3; wr_stall = 2;
    sw = 18'h1234A;
    push_wr(18'h1234A);
    push_ch(18'h1234A, 16'd2);
    wait_empty("stall_write", 80);
    chk("stall_reads", rd_acc - r0, 1);
    chk("stall_writes", wr_acc - w0, 1);
    chk("rd_stall_used", rd_stall, 0);
    chk("wr_stall_used", wr_stall, 0);

    // Saturation of the change counter.
    force dut.change_count = 16'hFFFE;
    @(negedge clk);
    release dut.change_count;
    sw = 18'h00001;
    push_wr(18'h00001);
    push_ch(18'h00001, 16'hFFFF);
    wait_empty("sat_write1", 60);
    sw = 18'h00002;
    push_wr(18'h00002);
    push_ch(18'h00002, 16'hFFFF);
    wait_empty("sat_write2", 60);

    // Reset while a write is stalled.
    sw = 18'h15555;
    push_ch(18'h15555, 16'hFFFF);
    wr_stall = 1000;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wr) break;
    end
    chk("reach_wr", i < 60, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wr", 32'(wr), 0);
    chk("async_rd", 32'(rd), 0);
    chk("async_addr", 32'(address), 0);
    chk("async_last", 32'(lv), 0);
    chk("async_count", 32'(cc), 0);
    wr_stall = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_wr(18'h15555);
    wait_empty("rewrite_after_reset", 60);
    repeat (20) @(negedge clk);
    chk("count_after_reset", 32'(cc), 0);
    chk("last_after_reset", 32'(lv), 32'h15555);

    // READ_LATENCY=3 instance: earlier readdata cycles carry garbage.
    enable = 1'b0;
    wq3.push_back('{a: 16'h0010, d: 32'h0002C0DE});
    enable3 = 1'b1;
    wait_empty("lat3_first", 60);
    sw3 = 18'h00ABC;
    wq3.push_back('{a: 16'h0010, d: 32'h00000ABC});
    wait_empty("lat3_change", 60);
    @(negedge clk);
    chk("lat3_last", 32'(lv3), 32'h00ABC);
    chk("lat3_count", 32'(cc3), 1);

    repeat (4) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
